sevseg_scan_sequencer: RTL

Time-multiplexing scan controller for the eight-digit seven-segment display owned by the system controller.
- Steps through the enabled digits and drives an active-low anode select plus the 4-bit digit value to the segment decoder.
- Dwell time and inter-digit blanking are programmable.
- Supports leading-zero suppression and emits a frame-done strobe.
- Configuration is shadowed per frame, so register writes from the Wishbone side never tear a frame.

---
 rtl/sevseg_scan_sequencer.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sevseg_scan_sequencer.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// sevseg_scan_sequencer
//
// Time-multiplexing scan controller for an eight-digit seven-segment display.
// It walks the enabled digits in ascending index order. For each digit it
// drives one active-low anode together with that digit's 4-bit value for a
// programmable dwell time. An optional all-off blanking gap follows each
// digit. Leading-zero suppression can hide high-order zero digits. A
// one-cycle frame-done strobe marks the end of each frame.
//
// All configuration is sampled into shadow registers only at frame start.
// Frame start is the IDLE->DRIVE transition or a frame wrap. Register writes
// arriving mid-frame therefore never tear the frame currently on the glass.
//
// Ports
//   i_clk         clock
//   i_rst         synchronous, active-high reset
//   i_run         1 = scanning enabled
//   i_enables     per-digit enable, 1 = digit may be lit
//   i_digits      digit k value is i_digits[4k+3:4k]
//   i_lzs         leading-zero suppression enable
//   i_dwell       cycles each digit is driven (0 behaves as 1)
//   i_blank       all-off cycles after each digit
//   o_an          anode select, active-low, at most one bit low
//   o_nibble      value of the digit currently (or last) driven
//   o_digit_idx   index of the digit currently (or last) driven
//   o_frame_done  one-cycle pulse at frame end
// -----------------------------------------------------------------------------
module sevseg_scan_sequencer #(
    parameter int N_DIGITS = 8,
    parameter int DWELL_W  = 20,
    parameter int BLANK_W  = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_run,
    input  logic [N_DIGITS-1:0]         i_enables,
    input  logic [4*N_DIGITS-1:0]       i_digits,
    input  logic                        i_lzs,
    input  logic [DWELL_W-1:0]          i_dwell,
    input  logic [BLANK_W-1:0]          i_blank,
    output logic [N_DIGITS-1:0]         o_an,
    output logic [3:0]                  o_nibble,
    output logic [$clog2(N_DIGITS)-1:0] o_digit_idx,
    output logic                        o_frame_done
);

    localparam int IDX_W = $clog2(N_DIGITS);
    // One shared down-counter serves both the dwell and the blank phases.
    localparam int CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_BLANK = 2'd2;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Effective digit mask: enabled and not suppressed. A digit is suppressed
    // only when suppression is on, it is not digit 0, and it and every digit
    // above it hold zero.
    function automatic logic [N_DIGITS-1:0] eff_mask(
        input logic [N_DIGITS-1:0]   en,
        input logic [4*N_DIGITS-1:0] digits,
        input logic                  lzs
    );
        logic [N_DIGITS-1:0] eff;
        logic                tail_zero;
        tail_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            tail_zero = tail_zero & (digits[4*k +: 4] == 4'd0);
            eff[k]    = en[k] & ~(lzs & tail_zero & (k != 0));
        end
        return eff;
    endfunction

    // Index of the lowest set bit; 0 when the mask is empty. Callers always
    // qualify the result with a nonzero check.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [N_DIGITS-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            if (m[k]) begin
                r = IDX_W'(k);
            end
        end
        return r;
    endfunction

    // Bits of m strictly above position idx.
    function automatic logic [N_DIGITS-1:0] above(
        input logic [N_DIGITS-1:0] m,
        input logic [IDX_W-1:0]    idx
    );
        logic [N_DIGITS-1:0] r;
        for (int k = 0; k < N_DIGITS; k++) begin
            r[k] = m[k] & (k > int'(idx));
        end
        return r;
    endfunction

    function automatic logic [N_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
        logic [N_DIGITS-1:0] an;
        an      = '1;
        an[idx] = 1'b0;
        return an;
    endfunction

    function automatic logic [3:0] nibble_at(
        input logic [4*N_DIGITS-1:0] digits,
        input logic [IDX_W-1:0]      idx
    );
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (k == int'(idx)) begin
                r = digits[4*k +: 4];
            end
        end
        return r;
    endfunction

    // The counter holds "cycles remaining after this one". A phase of n
    // cycles therefore loads n-1, and the phase ends on the cycle where the
    // counter reads zero. A dwell of 0 is treated as 1.
    function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] dwell);
        return (dwell == '0) ? '0 : CNT_W'(dwell) - CNT_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State and shadow registers
    // -------------------------------------------------------------------------
    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [N_DIGITS-1:0]   sh_enables;
    logic [4*N_DIGITS-1:0] sh_digits;
    logic                  sh_lzs;
    logic [DWELL_W-1:0]    sh_dwell;
    logic [BLANK_W-1:0]    sh_blank;

    // -------------------------------------------------------------------------
    // Mask evaluation
    // -------------------------------------------------------------------------
    logic [N_DIGITS-1:0] live_eff;     // mask of the values that would be latched
    logic [IDX_W-1:0]    live_first;
    logic [N_DIGITS-1:0] sh_eff;       // mask of the frame in progress
    logic [N_DIGITS-1:0] sh_higher;    // remaining digits of this frame
    logic [IDX_W-1:0]    sh_next;

    assign live_eff   = eff_mask(i_enables, i_digits, i_lzs);
    assign live_first = lowest_set(live_eff);
    assign sh_eff     = eff_mask(sh_enables, sh_digits, sh_lzs);
    assign sh_higher  = above(sh_eff, o_digit_idx);
    assign sh_next    = lowest_set(sh_higher);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic [1:0]          state_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [N_DIGITS-1:0] an_d;
    logic [3:0]          nibble_d;
    logic [IDX_W-1:0]    idx_d;
    logic                frame_done_d;
    logic                slot_end;      // last cycle of a digit's slot
    logic                start_live;    // start a frame from the live inputs
    logic                start_shadow;  // advance within the current frame
    logic                relatch;       // capture live inputs into the shadows

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d      = state;
        cnt_d        = cnt;
        an_d         = o_an;
        nibble_d     = o_nibble;
        idx_d        = o_digit_idx;
        frame_done_d = 1'b0;
        slot_end     = 1'b0;
        start_live   = 1'b0;
        start_shadow = 1'b0;
        relatch      = 1'b0;

        case (state)
            ST_IDLE: begin
                an_d = '1;
                if (i_run && (live_eff != '0)) begin
                    start_live = 1'b1;
                end
            end

            ST_DRIVE: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else if (sh_blank != '0) begin
                    state_d = ST_BLANK;
                    an_d    = '1;
                    cnt_d   = CNT_W'(sh_blank) - CNT_W'(1);
                end else begin
                    slot_end = 1'b1;
                end
            end

            ST_BLANK: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    slot_end = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                an_d    = '1;
            end
        endcase

        if (slot_end) begin
            if (!i_run) begin
                // Stop after this digit. The strobe fires only when this
                // digit also closed the frame.
                state_d      = ST_IDLE;
                an_d         = '1;
                frame_done_d = (sh_higher == '0);
            end else if (sh_higher != '0) begin
                start_shadow = 1'b1;
            end else begin
                // Frame wrap: the strobe lines up with the first cycle of
                // whatever follows. The new configuration is sampled here.
                frame_done_d = 1'b1;
                relatch      = 1'b1;
                if (live_eff != '0) begin
                    start_live = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    an_d    = '1;
                end
            end
        end

        if (start_live) begin
            state_d  = ST_DRIVE;
            idx_d    = live_first;
            an_d     = anode_for(live_first);
            nibble_d = nibble_at(i_digits, live_first);
            cnt_d    = dwell_load(i_dwell);
        end

        if (start_shadow) begin
            state_d  = ST_DRIVE;
            idx_d    = sh_next;
            an_d     = anode_for(sh_next);
            nibble_d = nibble_at(sh_digits, sh_next);
            cnt_d    = dwell_load(sh_dwell);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            sh_enables   <= '0;
            sh_digits    <= '0;
            sh_lzs       <= 1'b0;
            sh_dwell     <= '0;
            sh_blank     <= '0;
            o_an         <= '1;
            o_nibble     <= 4'd0;
            o_digit_idx  <= '0;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            o_an         <= an_d;
            o_nibble     <= nibble_d;
            o_digit_idx  <= idx_d;
            o_frame_done <= frame_done_d;
            if (start_live || relatch) begin
                sh_enables <= i_enables;
                sh_digits  <= i_digits;
                sh_lzs     <= i_lzs;
                sh_dwell   <= i_dwell;
                sh_blank   <= i_blank;
            end
        end
    end

endmodule
